// File: rtl/next_pc_controller_pkg.sv
// Shared definitions for the next-PC controller: FSM state codes and PC constants.
package next_pc_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT_STEP = 2'd1,
    ST_HALTED    = 2'd2
  } pc_state_e;

  localparam int unsigned PC_INCR          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_controller_if.sv
// Bus between the fetch/hazard/debug side (master) and the next-PC controller (slave).
interface next_pc_controller_if #(
  parameter int unsigned NB = 32
);
  logic [NB-1:0] i_pc;
  logic          i_stall;
  logic          i_branch_taken;
  logic [NB-1:0] i_branch_target;
  logic          i_jump;
  logic [NB-1:0] i_jump_target;
  logic          i_halt_instr;
  logic          i_debug_mode;
  logic          i_step;
  logic          o_write_new_pc;
  logic [NB-1:0] o_new_pc;
  logic [NB-1:0] o_pc_plus4;
  logic          o_flush_if;
  logic          o_halted;
  logic [1:0]    o_state;

  modport master (
    output i_pc, i_stall, i_branch_taken, i_branch_target, i_jump, i_jump_target,
           i_halt_instr, i_debug_mode, i_step,
    input  o_write_new_pc, o_new_pc, o_pc_plus4, o_flush_if, o_halted, o_state
  );

  modport slave (
    input  i_pc, i_stall, i_branch_taken, i_branch_target, i_jump, i_jump_target,
           i_halt_instr, i_debug_mode, i_step,
    output o_write_new_pc, o_new_pc, o_pc_plus4, o_flush_if, o_halted, o_state
  );
endinterface

// File: rtl/next_pc_controller_redirect_buffer.sv
// Holds one redirect target that arrived while the PC was frozen, until an advance cycle.
module pc_redirect_buffer #(
  parameter int unsigned NB = 32
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_capture,
  input  logic [NB-1:0] i_capture_target,
  input  logic          i_consume,
  output logic          o_pend_valid,
  output logic [NB-1:0] o_pend_target
);

  logic          pend_valid_q, pend_valid_d;
  logic [NB-1:0] pend_target_q, pend_target_d;

  // Any advance empties the buffer: either the entry is used or a live redirect supersedes it.
  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (i_consume) begin
      pend_valid_d = 1'b0;
    end else if (i_capture) begin
      pend_valid_d  = 1'b1;
      pend_target_d = i_capture_target;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign o_pend_valid  = pend_valid_q;
  assign o_pend_target = pend_target_q;

endmodule

// File: rtl/next_pc_controller.sv
// Write-side driver of the fetch PC register: sequential/redirect selection, stalls,
// single-step gating and permanent stop on HALT.
module next_pc_controller
  import next_pc_controller_pkg::*;
#(
  parameter int unsigned   NB       = 32,
  parameter logic [NB-1:0] RESET_PC = NB'(DEFAULT_RESET_PC)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  next_pc_controller_if.slave   bus
);

  pc_state_e     state_q, state_d;
  logic          pend_valid;
  logic [NB-1:0] pend_target;

  logic          live_redir;
  logic [NB-1:0] live_target;
  logic          redir_valid;
  logic [NB-1:0] redir_target;
  logic [NB-1:0] pc_plus4;
  logic          gate;
  logic          adv;
  logic          capture;
  logic          write_new_pc;
  logic [NB-1:0] new_pc;
  logic          flush_if;

  always_comb begin
    live_redir   = bus.i_branch_taken | bus.i_jump;
    live_target  = bus.i_branch_taken ? bus.i_branch_target : bus.i_jump_target;
    redir_valid  = live_redir | pend_valid;
    redir_target = live_redir ? live_target : pend_target;
    pc_plus4     = bus.i_pc + NB'(PC_INCR);

    gate    = (state_q == ST_RUN) || ((state_q == ST_WAIT_STEP) && bus.i_step);
    adv     = gate && !bus.i_stall;
    capture = !adv && live_redir && (state_q != ST_HALTED);

    write_new_pc = 1'b0;
    new_pc       = bus.i_pc;
    flush_if     = 1'b0;
    if (i_reset) begin
      write_new_pc = 1'b1;
      new_pc       = RESET_PC;
      flush_if     = 1'b1;
    end else if (adv) begin
      write_new_pc = 1'b1;
      new_pc       = redir_valid ? redir_target : pc_plus4;
      flush_if     = redir_valid;
    end
  end

  // A HALT seen alongside a redirect is on the wrong path and must not stop fetch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN, ST_WAIT_STEP: begin
        if (adv && bus.i_halt_instr && !redir_valid) begin
          state_d = ST_HALTED;
        end else if ((state_q == ST_RUN) && bus.i_debug_mode) begin
          state_d = ST_WAIT_STEP;
        end else if ((state_q == ST_WAIT_STEP) && !bus.i_debug_mode) begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  pc_redirect_buffer #(
    .NB (NB)
  ) u_redirect_buffer (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_capture        (capture),
    .i_capture_target (live_target),
    .i_consume        (adv),
    .o_pend_valid     (pend_valid),
    .o_pend_target    (pend_target)
  );

  assign bus.o_write_new_pc = write_new_pc;
  assign bus.o_new_pc       = new_pc;
  assign bus.o_pc_plus4     = pc_plus4;
  assign bus.o_flush_if     = flush_if;
  assign bus.o_halted       = (state_q == ST_HALTED);
  assign bus.o_state        = state_q;

endmodule

// File: tb/tb_next_pc_controller.sv
// Scoreboard bench for next_pc_controller: a behavioural model predicts each cycle's
// outputs, the bench owns the PC register and feeds it back as i_pc.
module tb_next_pc_controller;
  import next_pc_controller_pkg::*;

  typedef struct {
    logic        w;
    logic [31:0] np;
    logic        fl;
    logic [31:0] p4;
    logic [1:0]  st;
    logic        st_ok;
  } exp_t;

  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clock = ~i_clock;

  next_pc_controller_if #(.NB(32)) bus ();

  next_pc_controller #(
    .NB       (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [1:0]  m_state  = 2'd0;
  logic        m_known  = 1'b0;
  logic        m_pend_v = 1'b0;
  logic [31:0] m_pend_t = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s pc=%08h got=%08h exp=%08h", tag, bus.i_pc, got, exp);
    end
  endtask

  task automatic clear_pulses();
    bus.i_stall        = 1'b0;
    bus.i_branch_taken = 1'b0;
    bus.i_jump         = 1'b0;
    bus.i_halt_instr   = 1'b0;
    bus.i_step         = 1'b0;
  endtask

  // Predict, sample at the falling edge, then commit model state and PC after the rising edge.
  task automatic cycle();
    exp_t        e;
    exp_t        g;
    logic        live, redir, adv;
    logic [31:0] tgt;
    logic [1:0]  n_state;
    logic        n_pv;
    logic [31:0] n_pt;

    live  = bus.i_branch_taken || bus.i_jump;
    tgt   = bus.i_branch_taken ? bus.i_branch_target :
            (bus.i_jump ? bus.i_jump_target : m_pend_t);
    redir = live || m_pend_v;
    e.p4    = bus.i_pc + 32'd4;
    e.st    = m_state;
    e.st_ok = m_known;
    n_state = m_state;
    n_pv    = m_pend_v;
    n_pt    = m_pend_t;

    if (i_reset) begin
      e.w = 1'b1; e.np = 32'h0; e.fl = 1'b1;
      n_state = 2'd0; n_pv = 1'b0;
    end else if (m_state == 2'd2) begin
      e.w = 1'b0; e.np = bus.i_pc; e.fl = 1'b0;
    end else begin
      adv = ((m_state == 2'd0) || bus.i_step) && !bus.i_stall;
      if (adv) begin
        e.w  = 1'b1;
        e.np = redir ? tgt : bus.i_pc + 32'd4;
        e.fl = redir;
        n_pv = 1'b0;
        if (bus.i_halt_instr && !redir) n_state = 2'd2;
      end else begin
        e.w = 1'b0; e.np = bus.i_pc; e.fl = 1'b0;
        if (live) begin
          n_pv = 1'b1;
          n_pt = bus.i_branch_taken ? bus.i_branch_target : bus.i_jump_target;
        end
      end
      if (n_state != 2'd2) begin
        if (m_state == 2'd0 && bus.i_debug_mode) n_state = 2'd1;
        else if (m_state == 2'd1 && !bus.i_debug_mode) n_state = 2'd0;
      end
    end
    sb.push_back(e);

    @(negedge i_clock);
    g = sb.pop_front();
    check("write", {31'b0, bus.o_write_new_pc}, {31'b0, g.w});
    check("new_pc", bus.o_new_pc, g.np);
    check("flush", {31'b0, bus.o_flush_if}, {31'b0, g.fl});
    check("plus4", bus.o_pc_plus4, g.p4);
    if (g.st_ok) begin
      check("state", {30'b0, bus.o_state}, {30'b0, g.st});
      check("halted", {31'b0, bus.o_halted}, {31'b0, (g.st == 2'd2)});
    end

    @(posedge i_clock);
    #1;
    if (i_reset) m_known = 1'b1;
    m_state  = n_state;
    m_pend_v = n_pv;
    m_pend_t = n_pt;
    if (g.w) bus.i_pc = g.np;
    clear_pulses();
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) cycle();
  endtask

  initial begin
    bus.i_pc            = 32'h0000_1234;
    bus.i_branch_target = '0;
    bus.i_jump_target   = '0;
    bus.i_debug_mode    = 1'b0;
    clear_pulses();
    @(posedge i_clock);
    #1;

    // Reset with a live redirect present: reset vector must still win.
    i_reset = 1'b1;
    bus.i_jump = 1'b1; bus.i_jump_target = 32'h0000_0500;
    cycle();
    cycle();
    i_reset = 1'b0;
    run(4);                                   // 0x0 -> 0x10

    // Branch beats a simultaneous jump, then sequential.
    bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'h0000_0040;
    bus.i_jump = 1'b1;         bus.i_jump_target   = 32'h0000_0080;
    cycle();
    cycle();                                  // 0x44
    bus.i_jump = 1'b1; bus.i_jump_target = 32'h0000_001C;
    cycle();
    cycle();                                  // 0x20

    // Stall three cycles, jump captured during the second.
    bus.i_stall = 1'b1; cycle();
    bus.i_stall = 1'b1; bus.i_jump = 1'b1; bus.i_jump_target = 32'h0000_0100; cycle();
    bus.i_stall = 1'b1; cycle();
    cycle();                                  // 0x100, flush
    cycle();

    // Newer capture overwrites older; a live jump on the advance drops the pending entry.
    bus.i_stall = 1'b1; bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'h0000_0200; cycle();
    bus.i_stall = 1'b1; bus.i_jump = 1'b1; bus.i_jump_target = 32'h0000_0240; cycle();
    bus.i_jump = 1'b1; bus.i_jump_target = 32'h0000_0300; cycle();
    cycle();                                  // 0x304, no stale redirect

    // Single-step mode.
    bus.i_debug_mode = 1'b1;
    cycle();                                  // still RUN this cycle
    run(3);                                   // waiting, no writes
    bus.i_step = 1'b1; cycle();
    cycle();
    bus.i_step = 1'b1; bus.i_stall = 1'b1; cycle();
    bus.i_step = 1'b1; cycle();
    bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'h0000_0028; cycle();
    cycle();
    bus.i_step = 1'b1; cycle();               // pending 0x28 applied
    bus.i_debug_mode = 1'b0;
    cycle();
    cycle();                                  // back in RUN

    // Wrong-path HALT alongside a jump is ignored.
    bus.i_halt_instr = 1'b1; bus.i_jump = 1'b1; bus.i_jump_target = 32'h0000_002C; cycle();
    cycle();                                  // 0x30
    bus.i_halt_instr = 1'b1; cycle();
    bus.i_step = 1'b1; bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'h0000_0700; cycle();
    run(3);
    i_reset = 1'b1; cycle();
    i_reset = 1'b0;
    run(2);

    // PC wraparound.
    bus.i_jump = 1'b1; bus.i_jump_target = 32'hFFFF_FFFC; cycle();
    cycle();
    cycle();

    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard leftover=%0d", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

endmodule
